// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO in front of the frame serializer.
// Frames are start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          tx_start,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_full,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 push;
    logic                 pop;

    // A push is judged on the registered full flag, so a same-cycle pop never frees room for it.
    always_comb begin
        push = tx_start && !tx_full;
        pop  = (state == IDLE) && (fifo_count != '0);
    end

    assign tx_busy = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_full    <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
                tx_full    <= (fifo_count == CW'(FIFO_DEPTH - 1));
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
                tx_full    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        par_bit <= (PARITY == 2) ? ~(^mem[rd_ptr]) : ^mem[rd_ptr];
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PAR: begin
                    if (baud_tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning payload bits per frame, legal 5..8.
REQ-002 Parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd; value 3 is illegal.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, meaning queued words, a power of two from 2 to 64.
REQ-005 Port clk, input, 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port baud_tick, input, 1, one-clk-wide bit-period strobe.
REQ-008 Port tx_start, input, 1, write strobe, sampled every clk.
REQ-009 Port tx_data, input, DATA_BITS, word written when tx_start is accepted.
REQ-010 Port tx, output, 1, serial line, idle high.
REQ-011 Port tx_busy, output, 1, high while the FIFO is non-empty or a frame is in progress.
REQ-012 Port tx_full, output, 1, high when the FIFO holds FIFO_DEPTH words.
REQ-013 Port tx_done, output, 1, one-clk pulse at the end of each frame.
REQ-014 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of words currently queued.

Function
REQ-015 A write SHALL be accepted when tx_start=1 and tx_full=0 at the clk edge; a write attempted while tx_full=1 SHALL be dropped silently, even if a pop occurs in the same cycle.
REQ-016 The FIFO SHALL use wrapping read and write pointers; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-018 In IDLE with fifo_count>0, the FSM SHALL pop the head word into a shift register and enter START on the next clk; the pop SHALL NOT wait for baud_tick.
REQ-019 In START, tx SHALL be 0; on baud_tick the FSM SHALL clear the bit counter and enter DATA.
REQ-020 In DATA, tx SHALL be data bit [bit counter], LSB first; on baud_tick the bit counter SHALL increment, and at counter = DATA_BITS-1 the FSM SHALL enter PAR if PARITY≠0, otherwise STOP.
REQ-021 In PAR, tx SHALL be the XOR of the data bits for even parity and the inverse of that XOR for odd parity; on baud_tick the FSM SHALL enter STOP.
REQ-022 In STOP, tx SHALL be 1; the FSM SHALL remain for STOP_BITS baud_ticks; on the last of these ticks tx_done SHALL pulse and the FSM SHALL return to IDLE.
REQ-023 Back-to-back frames: when the FIFO is non-empty at the return to IDLE, START SHALL begin one clk later, with no idle bit period inserted.
REQ-024 A baud_tick arriving in IDLE SHALL be ignored.
REQ-025 The first START period may be shortened by up to one baud period, because it is not phase-aligned to baud_tick; this behaviour is accepted.
REQ-026 tx SHALL be driven from a register, so it is glitch-free; tx_full and fifo_count SHALL be registered.
REQ-027 A change of tx_data after a write has been accepted SHALL NOT affect the queued word.

Reset
REQ-028 On reset=1 at a clk edge the block SHALL force: FSM to IDLE, FIFO pointers and count to 0, tx=1, tx_busy=0, tx_full=0, tx_done=0, fifo_count=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued words; no tx_done SHALL pulse.
REQ-030 Writes presented while reset=1 SHALL be ignored.

Verification
REQ-031 Defaults, write 0xA5, baud_tick every 16 clk -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held one baud period, one tx_done pulse, tx_busy low afterwards.
REQ-032 PARITY=1 with 0x07, then PARITY=2 with 0x07 -> parity bit 1 for even, 0 for odd; with STOP_BITS=2 the line stays high for 2 baud periods before tx_done.
REQ-033 DATA_BITS=5, write 0x1F -> exactly 5 data bits of 1 follow the start bit; bits 7:5 are never transmitted.
REQ-034 FIFO_DEPTH=4, five writes in consecutive clks while idle -> the first is popped immediately, the next 4 fill the FIFO, tx_full rises, and a sixth write is dropped; 5 frames are sent back-to-back in write order.
REQ-035 Reset asserted during DATA bit 3 with 2 words queued -> next clk tx=1, fifo_count=0, tx_busy=0, no tx_done, and no further frames are sent.
REQ-036 tx_start held at the same clk as the last stop baud_tick with the FIFO empty -> the word is accepted, START begins within 2 clk, and fifo_count never exceeds 1.
